synchro_universal_register: RTL and testbench
=============================================

// Module: synchro_universal_register
// PURPOSE
//  Parametrised successor of the synchronous zeros/ones register: N-bit register
//  with synchronous clear, set, parallel load, shift/rotate and up/down count.
//  Priority-encoded command inputs, registered carry/borrow and zero flags.
//  Used as a general working register / counter on the Arty datapath.
// PARAMETERS
//  N           4     register width in bits (N >= 2)
//  RESET_VALUE 0     value of BUS after RESET (N bits)
//  SATURATE    0     0: INC/DEC wrap modulo 2^N; 1: INC/DEC clamp at all-ones/zero
// PORTS
//  CLK     in   1   clock, all state updates on rising edge
//  RESET   in   1   asynchronous, active-high reset
//  ZEROES  in   1   synchronous clear command
//  ONES    in   1   synchronous set-all command
//  LOAD    in   1   parallel load of D
//  D       in   N   parallel data
//  SHL     in   1   shift left (towards MSB)
//  SHR     in   1   shift right (towards LSB)
//  ROT     in   1   qualifier: SHL/SHR rotate instead of shifting in SIN
//  SIN     in   1   serial input bit for non-rotating shifts
//  INC     in   1   increment by 1
//  DEC     in   1   decrement by 1
//  BUS     out  N   register contents
//  CARRY   out  1   registered carry/borrow/shifted-out bit of last operation
//  ZERO    out  1   registered flag, 1 when BUS == 0
// BEHAVIOUR
//  - Clock and reset: one clock, CLK. RESET is asynchronous and active-high; it acts
//    immediately, independent of CLK. While RESET = 1: BUS = RESET_VALUE,
//    CARRY = 0, ZERO = (RESET_VALUE == 0).
//  - One operation per rising edge. Fixed priority:
//    ZEROES > ONES > LOAD > SHL > SHR > INC > DEC > hold.
//    Lower-priority commands asserted in the same cycle are ignored.
//  - Latency: the result appears on BUS one edge after the command is sampled.
//    CARRY and ZERO update on the same edge as BUS and always match the new BUS value.
//  - ZEROES: BUS <= 0, CARRY <= 0.  ONES: BUS <= all-ones, CARRY <= 0.
//  - LOAD: BUS <= D, CARRY <= 0.
//  - SHL: BUS <= {BUS[N-2:0], ROT ? BUS[N-1] : SIN}, CARRY <= old BUS[N-1].
//  - SHR: BUS <= {ROT ? BUS[0] : SIN, BUS[N-1:1]}, CARRY <= old BUS[0].
//  - ROT alone, with no SHL/SHR, is a hold.
//  - INC: BUS <= BUS + 1 (N-bit). If old BUS is all-ones, CARRY <= 1.
//    In that case BUS wraps to 0 when SATURATE = 0, and stays all-ones when SATURATE = 1.
//    Otherwise CARRY <= 0.
//  - DEC: BUS <= BUS - 1 (N-bit). If old BUS == 0, CARRY <= 1 (borrow).
//    In that case BUS wraps to all-ones when SATURATE = 0, and stays 0 when SATURATE = 1.
//    Otherwise CARRY <= 0.
//  - Hold (no command): BUS unchanged, CARRY <= 0; ZERO still tracks BUS.
//  - ZERO is registered, i.e. computed from the next-state value, never combinational from BUS.
//  - INC and DEC together: INC wins by priority (not a net hold).
//  - RESET asserted mid-operation: state is forced at once. The first edge after
//    RESET falls executes the command sampled on that edge.
//  - No internal FSM beyond the register and the flags. All commands are level-sensitive
//    each cycle, so holding INC high counts every cycle.
// TESTING  (N=4, RESET_VALUE=0 unless stated)
//  1. Reset/priority: RESET pulse -> BUS=0000, ZERO=1, CARRY=0.
//     ONES=1 -> BUS=1111. Then ZEROES=1 and ONES=1 together -> BUS=0000.
//  2. Load/shift: LOAD D=1001 -> 1001.
//     SHL SIN=0 -> 0010, CARRY=1.
//     SHR ROT=1 -> 0001, CARRY=0.
//     SHR ROT=1 -> 1000, CARRY=1.
//  3. Wrap count (SATURATE=0): LOAD 1110, INC x2 -> 1111 (CARRY 0) then 0000
//     (CARRY 1, ZERO 1). DEC -> 1111, CARRY=1.
//  4. Saturate (SATURATE=1): LOAD 1111, INC -> BUS stays 1111, CARRY=1.
//     ZEROES, then DEC -> BUS stays 0000, CARRY=1.
//  5. Async reset mid-count (RESET_VALUE=0101): INC held high, RESET raised between
//     edges -> BUS=0101 before the next CLK edge. Counting resumes 0110 on the
//     first edge after RESET falls.
//  6. Same-cycle conflicts: LOAD D=0011 with SHL and INC -> 0011.
//     Then INC and DEC together -> 0100.

Source files
------------

// File: rtl/synchro_universal_register.sv
// N-bit working register: clear, set, load, shift/rotate, up/down count with
// priority-encoded commands and registered carry/borrow and zero flags.
module synchro_universal_register #(
  parameter int unsigned    N           = 4,
  parameter logic [N-1:0]   RESET_VALUE = '0,
  parameter bit             SATURATE    = 1'b0
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         ZEROES,
  input  logic         ONES,
  input  logic         LOAD,
  input  logic [N-1:0] D,
  input  logic         SHL,
  input  logic         SHR,
  input  logic         ROT,
  input  logic         SIN,
  input  logic         INC,
  input  logic         DEC,
  output logic [N-1:0] BUS,
  output logic         CARRY,
  output logic         ZERO
);

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLR,
    OP_SET,
    OP_LOAD,
    OP_SHL,
    OP_SHR,
    OP_INC,
    OP_DEC
  } op_t;

  logic [N-1:0] r_bus;
  logic         r_carry;
  logic         r_zero;

  op_t          w_op;
  logic [N-1:0] w_next_bus;
  logic         w_next_carry;
  logic         w_all_ones;
  logic         w_is_zero;
  logic         w_shl_in;
  logic         w_shr_in;

  assign w_all_ones = &r_bus;
  assign w_is_zero  = ~|r_bus;
  assign w_shl_in   = ROT ? r_bus[N-1] : SIN;
  assign w_shr_in   = ROT ? r_bus[0]   : SIN;

  always_comb begin
    w_op = OP_HOLD;
    if (ZEROES)    w_op = OP_CLR;
    else if (ONES) w_op = OP_SET;
    else if (LOAD) w_op = OP_LOAD;
    else if (SHL)  w_op = OP_SHL;
    else if (SHR)  w_op = OP_SHR;
    else if (INC)  w_op = OP_INC;
    else if (DEC)  w_op = OP_DEC;
  end

  always_comb begin
    w_next_bus   = r_bus;
    w_next_carry = 1'b0;
    unique case (w_op)
      OP_CLR:  w_next_bus = '0;
      OP_SET:  w_next_bus = '1;
      OP_LOAD: w_next_bus = D;
      OP_SHL: begin
        w_next_bus   = {r_bus[N-2:0], w_shl_in};
        w_next_carry = r_bus[N-1];
      end
      OP_SHR: begin
        w_next_bus   = {w_shr_in, r_bus[N-1:1]};
        w_next_carry = r_bus[0];
      end
      // At the limit the carry/borrow is flagged; saturation keeps the old value.
      OP_INC: begin
        w_next_carry = w_all_ones;
        w_next_bus   = (w_all_ones && SATURATE) ? r_bus : r_bus + 1'b1;
      end
      OP_DEC: begin
        w_next_carry = w_is_zero;
        w_next_bus   = (w_is_zero && SATURATE) ? r_bus : r_bus - 1'b1;
      end
      default: w_next_bus = r_bus;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_bus   <= RESET_VALUE;
      r_carry <= 1'b0;
      r_zero  <= (RESET_VALUE == '0);
    end else begin
      r_bus   <= w_next_bus;
      r_carry <= w_next_carry;
      r_zero  <= (w_next_bus == '0);
    end
  end

  assign BUS   = r_bus;
  assign CARRY = r_carry;
  assign ZERO  = r_zero;

endmodule

// File: tb/tb_synchro_universal_register.sv
// Bench for synchro_universal_register: three instances (wrap, saturate,
// non-zero reset value) sharing stimulus, checked against a queued model.
module tb_synchro_universal_register;

  typedef struct packed {
    logic       z, o, l, shl, shr, rot, sin, inc, dec;
    logic [3:0] d;
  } cmd_t;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       ZEROES, ONES, LOAD, SHL, SHR, ROT, SIN, INC, DEC;
  logic [3:0] D;
  logic [3:0] bus_a, bus_b, bus_c;
  logic       car_a, car_b, car_c, zer_a, zer_b, zer_c;

  int total = 0;
  int bad   = 0;

  logic [3:0] m_a, m_b, m_c;
  logic [17:0] exp_q[$];

  always #5 CLK = ~CLK;

  synchro_universal_register #(.N(4), .RESET_VALUE(4'b0000), .SATURATE(1'b0)) u_wrap (
    .CLK(CLK), .RESET(RESET), .ZEROES(ZEROES), .ONES(ONES), .LOAD(LOAD), .D(D),
    .SHL(SHL), .SHR(SHR), .ROT(ROT), .SIN(SIN), .INC(INC), .DEC(DEC),
    .BUS(bus_a), .CARRY(car_a), .ZERO(zer_a));

  synchro_universal_register #(.N(4), .RESET_VALUE(4'b0000), .SATURATE(1'b1)) u_sat (
    .CLK(CLK), .RESET(RESET), .ZEROES(ZEROES), .ONES(ONES), .LOAD(LOAD), .D(D),
    .SHL(SHL), .SHR(SHR), .ROT(ROT), .SIN(SIN), .INC(INC), .DEC(DEC),
    .BUS(bus_b), .CARRY(car_b), .ZERO(zer_b));

  synchro_universal_register #(.N(4), .RESET_VALUE(4'b0101), .SATURATE(1'b0)) u_rv (
    .CLK(CLK), .RESET(RESET), .ZEROES(ZEROES), .ONES(ONES), .LOAD(LOAD), .D(D),
    .SHL(SHL), .SHR(SHR), .ROT(ROT), .SIN(SIN), .INC(INC), .DEC(DEC),
    .BUS(bus_c), .CARRY(car_c), .ZERO(zer_c));

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  // Returns {carry, bus}, computed arithmetically on an integer value.
  function automatic logic [4:0] model_next(input logic [3:0] b, input bit sat, input cmd_t c);
    int v;
    int nv;
    logic cy;
    v  = int'(b);
    nv = v;
    cy = 1'b0;
    if (c.z)        nv = 0;
    else if (c.o)   nv = 15;
    else if (c.l)   nv = int'(c.d);
    else if (c.shl) begin
      cy = (v >= 8);
      nv = ((v * 2) % 16) + (c.rot ? int'(v >= 8) : int'(c.sin));
    end else if (c.shr) begin
      cy = (v % 2 == 1);
      nv = (v / 2) + 8 * (c.rot ? (v % 2) : int'(c.sin));
    end else if (c.inc) begin
      if (v == 15) begin cy = 1'b1; nv = sat ? 15 : 0; end
      else nv = v + 1;
    end else if (c.dec) begin
      if (v == 0) begin cy = 1'b1; nv = sat ? 0 : 15; end
      else nv = v - 1;
    end
    return {cy, nv[3:0]};
  endfunction

  function automatic logic [5:0] pack_exp(input logic [4:0] cb);
    return {(cb[3:0] == 4'd0), cb};
  endfunction

  task automatic drive(input cmd_t c);
    ZEROES = c.z; ONES = c.o; LOAD = c.l; SHL = c.shl; SHR = c.shr;
    ROT = c.rot; SIN = c.sin; INC = c.inc; DEC = c.dec; D = c.d;
  endtask

  // Drive one command at the falling edge, queue the expectation, check after the rising edge.
  task automatic step(input cmd_t c);
    logic [4:0]  na, nb, nc;
    logic [17:0] e;
    drive(c);
    na = model_next(m_a, 1'b0, c);
    nb = model_next(m_b, 1'b1, c);
    nc = model_next(m_c, 1'b0, c);
    exp_q.push_back({pack_exp(na), pack_exp(nb), pack_exp(nc)});
    m_a = na[3:0]; m_b = nb[3:0]; m_c = nc[3:0];
    @(posedge CLK);
    #1;
    e = exp_q.pop_front();
    check_eq("wrap_bus", {4'd0, bus_a}, {4'd0, e[15:12]});
    check_eq("wrap_flg", {6'd0, zer_a, car_a}, {6'd0, e[17:16]});
    check_eq("sat_bus",  {4'd0, bus_b}, {4'd0, e[9:6]});
    check_eq("sat_flg",  {6'd0, zer_b, car_b}, {6'd0, e[11:10]});
    check_eq("rv_bus",   {4'd0, bus_c}, {4'd0, e[3:0]});
    check_eq("rv_flg",   {6'd0, zer_c, car_c}, {6'd0, e[5:4]});
    @(negedge CLK);
  endtask

  function automatic cmd_t mk(input string op, input logic [3:0] d = 4'd0, input logic rot = 1'b0, input logic sin = 1'b0);
    cmd_t c;
    c = '0;
    c.d = d; c.rot = rot; c.sin = sin;
    case (op)
      "Z":   c.z = 1'b1;
      "O":   c.o = 1'b1;
      "ZO":  begin c.z = 1'b1; c.o = 1'b1; end
      "L":   c.l = 1'b1;
      "LSI": begin c.l = 1'b1; c.shl = 1'b1; c.inc = 1'b1; end
      "SHL": c.shl = 1'b1;
      "SHR": c.shr = 1'b1;
      "I":   c.inc = 1'b1;
      "D":   c.dec = 1'b1;
      "ID":  begin c.inc = 1'b1; c.dec = 1'b1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic reset_models();
    m_a = 4'b0000; m_b = 4'b0000; m_c = 4'b0101;
  endtask

  initial begin
    cmd_t c;
    RESET = 1'b1;
    drive('0);
    reset_models();
    repeat (2) @(negedge CLK);
    check_eq("rst_bus",   {4'd0, bus_a}, 8'h00);
    check_eq("rst_zero",  {7'd0, zer_a}, 8'h01);
    check_eq("rst_carry", {7'd0, car_a}, 8'h00);
    check_eq("rst_rvbus", {4'd0, bus_c}, 8'h05);
    check_eq("rst_rvzero", {7'd0, zer_c}, 8'h00);
    RESET = 1'b0;

    step(mk("O"));       check_eq("t1_ones", {4'd0, bus_a}, 8'h0F);
    step(mk("ZO"));      check_eq("t1_zo",   {4'd0, bus_a}, 8'h00);

    step(mk("L", 4'b1001));             check_eq("t2_load", {4'd0, bus_a}, 8'h09);
    step(mk("SHL", 4'd0, 1'b0, 1'b0));  check_eq("t2_shl", {3'd0, car_a, bus_a}, 8'h12);
    step(mk("SHR", 4'd0, 1'b1));        check_eq("t2_ror1", {3'd0, car_a, bus_a}, 8'h01);
    step(mk("SHR", 4'd0, 1'b1));        check_eq("t2_ror2", {3'd0, car_a, bus_a}, 8'h18);
    step(mk("SHL", 4'd0, 1'b0, 1'b1));  check_eq("shl_sin1", {3'd0, car_a, bus_a}, 8'h11);

    step(mk("L", 4'b1110));
    step(mk("I"));  check_eq("t3_inc1", {2'd0, zer_a, car_a, bus_a}, 8'h0F);
    step(mk("I"));  check_eq("t3_wrap", {2'd0, zer_a, car_a, bus_a}, 8'h30);
    step(mk("D"));  check_eq("t3_dec",  {2'd0, zer_a, car_a, bus_a}, 8'h1F);
    step(mk("HOLD")); check_eq("hold_carry", {3'd0, car_a, bus_a}, 8'h0F);
    step(mk("HOLD", 4'd0, 1'b1)); check_eq("rot_hold", {4'd0, bus_a}, 8'h0F);

    step(mk("L", 4'b1111));
    step(mk("I"));  check_eq("t4_satinc", {3'd0, car_b, bus_b}, 8'h1F);
    step(mk("Z"));
    step(mk("D"));  check_eq("t4_satdec", {2'd0, zer_b, car_b, bus_b}, 8'h30);

    step(mk("L", 4'b0010));
    step(mk("I"));
    step(mk("I"));
    #2 RESET = 1'b1;
    #1;
    check_eq("t5_async_rv", {4'd0, bus_c}, 8'h05);
    check_eq("t5_async_a",  {2'd0, zer_a, car_a, bus_a}, 8'h20);
    reset_models();
    @(posedge CLK); #1;
    check_eq("t5_held", {4'd0, bus_c}, 8'h05);
    @(negedge CLK);
    RESET = 1'b0;
    step(mk("I"));  check_eq("t5_resume", {4'd0, bus_c}, 8'h06);

    step(mk("LSI", 4'b0011)); check_eq("t6_load", {4'd0, bus_a}, 8'h03);
    step(mk("ID"));           check_eq("t6_incdec", {4'd0, bus_a}, 8'h04);

    for (int i = 0; i < 60; i++) begin
      c = '0;
      c.d = 4'($urandom_range(0, 15));
      c.rot = 1'($urandom_range(0, 1));
      c.sin = 1'($urandom_range(0, 1));
      c.z   = ($urandom_range(0, 15) == 0);
      c.o   = ($urandom_range(0, 15) == 0);
      c.l   = ($urandom_range(0, 7) == 0);
      c.shl = ($urandom_range(0, 3) == 0);
      c.shr = ($urandom_range(0, 3) == 0);
      c.inc = ($urandom_range(0, 2) == 0);
      c.dec = ($urandom_range(0, 2) == 0);
      step(c);
    end

    check_eq("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
